// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
// Engine states and divider limit.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LEAD,
        TRAIL,
        HOLD
    } state_e;

    localparam int MAX_DIV = 11;

    function automatic logic [3:0] clamp_div(input logic [3:0] d);
        return (d > 4'(MAX_DIV)) ? 4'(MAX_DIV) : d;
    endfunction

endpackage

// File: rtl/spi_fifo.sv
// Show-ahead synchronous FIFO with occupancy counter.
// Push on full only lands when a pop frees a slot in the same cycle.
module spi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign dout    = mem[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push}
                           - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end

endmodule

// File: rtl/spi_master.sv
// SPI master: TX/RX FIFOs, clock divider, mode-aware shift engine,
// one-hot chip selects and sticky RX overflow.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NCS        = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_cpol,
    input  logic                    cfg_cpha,
    input  logic                    cfg_lsb_first,
    input  logic [3:0]              cfg_div,
    input  logic [$clog2(NCS)-1:0]  cfg_cs_sel,
    input  logic                    cfg_cs_hold,
    input  logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_push,
    output logic                    tx_full,
    output logic [DATA_W-1:0]       rx_data,
    input  logic                    rx_pop,
    output logic                    rx_empty,
    output logic                    rx_ovf,
    input  logic                    ovf_clr,
    output logic                    busy,
    output logic                    sclk,
    output logic                    mosi,
    input  logic                    miso,
    output logic [NCS-1:0]          cs_n
);

    localparam int CSW = $clog2(NCS);
    localparam int BCW = $clog2(DATA_W + 1);
    localparam int CW  = MAX_DIV;

    state_e            state_q, state_d;
    logic [CW-1:0]     div_cnt_q;
    logic [CW-1:0]     rld;
    logic [3:0]        rld_div;
    logic [3:0]        div_q;
    logic              cpol_q, cpha_q, lsb_q;
    logic [CSW-1:0]    sel_q;
    logic              have_sel_q;
    logic [BCW-1:0]    bit_q;
    logic [DATA_W-1:0] tx_sh_q, rx_sh_q;
    logic              sclk_q, mosi_q, ovf_q;
    logic [NCS-1:0]    cs_q, cs_d;

    logic [DATA_W-1:0] tx_head;
    logic              tx_empty, rx_full;
    logic              tick, load, rx_push;
    logic              lead_e, trail_e, shift_e, sample_e, keep_cs;
    logic              head_bit, sh_bit;
    logic [DATA_W-1:0] head_nxt, sh_nxt;

    spi_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .din   (tx_data),
        .pop   (load),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    spi_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .din   (rx_sh_q),
        .pop   (rx_pop),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign tick     = (div_cnt_q == '0);
    assign load     = (state_q == IDLE) && !tx_empty;
    assign shift_e  = (lead_e && cpha_q) || (trail_e && !cpha_q);
    assign sample_e = (lead_e && !cpha_q) || (trail_e && cpha_q);
    assign keep_cs  = cfg_cs_hold && have_sel_q && (sel_q == cfg_cs_sel);

    assign head_bit = cfg_lsb_first ? tx_head[0] : tx_head[DATA_W-1];
    assign head_nxt = cfg_lsb_first ? {1'b0, tx_head[DATA_W-1:1]}
                                    : {tx_head[DATA_W-2:0], 1'b0};
    assign sh_bit   = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
    assign sh_nxt   = lsb_q ? {1'b0, tx_sh_q[DATA_W-1:1]}
                            : {tx_sh_q[DATA_W-2:0], 1'b0};

    assign rld_div = load ? clamp_div(cfg_div) : div_q;
    assign rld     = (CW'(1) << rld_div) - CW'(1);

    assign busy   = (state_q != IDLE) || !tx_empty;
    assign sclk   = sclk_q;
    assign mosi   = mosi_q;
    assign cs_n   = cs_q;
    assign rx_ovf = ovf_q;

    always_comb begin
        state_d = state_q;
        lead_e  = 1'b0;
        trail_e = 1'b0;
        rx_push = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!tx_empty) state_d = SETUP;
            end
            SETUP: begin
                if (tick) begin
                    state_d = LEAD;
                    lead_e  = 1'b1;
                end
            end
            LEAD: begin
                if (tick) begin
                    state_d = TRAIL;
                    trail_e = 1'b1;
                end
            end
            TRAIL: begin
                if (tick) begin
                    if (bit_q > BCW'(1)) begin
                        state_d = LEAD;
                        lead_e  = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = IDLE;
                    rx_push = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Chip select only changes at word boundaries.
    always_comb begin
        cs_d = cs_q;
        if (state_q == HOLD && tick) begin
            if (!keep_cs) cs_d = '1;
        end else if (state_q == IDLE) begin
            cs_d = '1;
            if (load)         cs_d[cfg_cs_sel] = 1'b0;
            else if (keep_cs) cs_d[sel_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            div_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            sel_q      <= '0;
            have_sel_q <= 1'b0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= '1;
            ovf_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;

            if (load || (state_q != IDLE && tick))
                div_cnt_q <= rld;
            else if (!tick)
                div_cnt_q <= div_cnt_q - 1'b1;

            if (load) begin
                cpol_q     <= cfg_cpol;
                cpha_q     <= cfg_cpha;
                lsb_q      <= cfg_lsb_first;
                div_q      <= clamp_div(cfg_div);
                sel_q      <= cfg_cs_sel;
                have_sel_q <= 1'b1;
                bit_q      <= BCW'(DATA_W);
                rx_sh_q    <= '0;
                mosi_q     <= head_bit;
                tx_sh_q    <= cfg_cpha ? tx_data_hold(tx_head) : head_nxt;
            end

            if (state_q == IDLE) sclk_q <= cfg_cpol;
            else if (lead_e)     sclk_q <= ~cpol_q;
            else if (trail_e)    sclk_q <= cpol_q;

            if (shift_e) begin
                mosi_q  <= sh_bit;
                tx_sh_q <= sh_nxt;
            end

            if (sample_e)
                rx_sh_q <= lsb_q ? {miso, rx_sh_q[DATA_W-1:1]}
                                 : {rx_sh_q[DATA_W-2:0], miso};

            if (state_q == TRAIL && tick) bit_q <= bit_q - 1'b1;

            // A new overflow beats a simultaneous clear.
            if (rx_push && rx_full && !rx_pop) ovf_q <= 1'b1;
            else if (ovf_clr)                  ovf_q <= 1'b0;
        end
    end

    // With cpha=1 the first leading edge re-emits the head bit.
    function automatic logic [DATA_W-1:0] tx_data_hold(
        input logic [DATA_W-1:0] w);
        return w;
    endfunction

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: loopback and slave-model
// transfers, all SPI modes, cs hold, RX overflow and async reset.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_cpol = 1'b0;
    logic       cfg_cpha = 1'b0;
    logic       cfg_lsb_first = 1'b0;
    logic [3:0] cfg_div = 4'd0;
    logic [1:0] cfg_cs_sel = 2'd0;
    logic       cfg_cs_hold = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_push = 1'b0;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_pop = 1'b0;
    logic       rx_empty;
    logic       rx_ovf;
    logic       ovf_clr = 1'b0;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [3:0] cs_n;

    always #5 clk = ~clk;

    spi_master #(.DATA_W(8), .NCS(4), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_cpol      (cfg_cpol),
        .cfg_cpha      (cfg_cpha),
        .cfg_lsb_first (cfg_lsb_first),
        .cfg_div       (cfg_div),
        .cfg_cs_sel    (cfg_cs_sel),
        .cfg_cs_hold   (cfg_cs_hold),
        .tx_data       (tx_data),
        .tx_push       (tx_push),
        .tx_full       (tx_full),
        .rx_data       (rx_data),
        .rx_pop        (rx_pop),
        .rx_empty      (rx_empty),
        .rx_ovf        (rx_ovf),
        .ovf_clr       (ovf_clr),
        .busy          (busy),
        .sclk          (sclk),
        .mosi          (mosi),
        .miso          (miso),
        .cs_n          (cs_n)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave model on cs_n[0]: drives s_tx MSB first, captures mosi.
    logic       loop = 1'b1;
    logic       t_cpol = 1'b0;
    logic       t_cpha = 1'b0;
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_rx = 8'h00;
    logic       miso_s = 1'b0;
    logic       cs0_p = 1'b1;
    logic       sclk_p = 1'b0;
    int         s_bit = 7;

    assign miso = loop ? mosi : miso_s;

    always @(cs_n[0] or sclk) begin
        if (cs_n[0] == 1'b0 && cs0_p == 1'b1) begin
            s_rx  = 8'h00;
            s_bit = 7;
            if (!t_cpha) begin
                miso_s = s_tx[7];
                s_bit  = 6;
            end
        end else if (cs_n[0] == 1'b0 && sclk != sclk_p) begin
            if ((sclk != t_cpol) != t_cpha) begin
                s_rx = {s_rx[6:0], mosi};
            end else if (s_bit >= 0) begin
                miso_s = s_tx[s_bit];
                s_bit--;
            end
        end
        cs0_p  = cs_n[0];
        sclk_p = sclk;
    end

    int n_rise = 0;
    always @(posedge sclk) n_rise++;

    int cs_bad = 0;
    logic mon_en = 1'b0;
    always @(negedge clk) if (mon_en && cs_n !== 4'b1011) cs_bad++;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        tx_data = d;
        tx_push = 1'b1;
        @(posedge clk);
        #1;
        tx_push = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    task automatic drain();
        logic [7:0] exp;
        int k;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            k = 0;
            while (rx_empty && k < 2000) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("rx_avail", rx_empty, 1'b0);
            chk("rx_data", rx_data, exp);
            rx_pop = 1'b1;
            @(posedge clk);
            #1;
            rx_pop = 1'b0;
        end
    endtask

    initial begin
        int k;
        int base;
        logic [7:0] txw;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(2);
        chk("rst_tx_full", tx_full, 1'b0);
        chk("rst_rx_empty", rx_empty, 1'b1);
        chk("rst_rx_ovf", rx_ovf, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_cs_n", cs_n, 4'b1111);

        // Mode 0, div 1, loopback
        cfg_div = 4'd1;
        loop = 1'b1;
        base = n_rise;
        push_word(8'hA5);
        sb.push_back(8'hA5);
        @(posedge clk);
        #1;
        chk("m0_cs_low", cs_n, 4'b1110);
        chk("m0_first_mosi", mosi, 1'b1);
        k = 0;
        while (rx_empty && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("m0_word_time", k, 36);
        chk("m0_sclk_rises", n_rise - base, 8);
        drain();
        wait_idle();

        // All four modes against the slave model
        loop = 1'b0;
        s_tx = 8'h3C;
        for (int m = 0; m < 4; m++) begin
            t_cpol = (m >= 2);
            t_cpha = (m % 2 == 1);
            cfg_cpol = t_cpol;
            cfg_cpha = t_cpha;
            cfg_div = 4'(m);
            cycles(2);
            chk("mode_sclk_idle", sclk, t_cpol);
            txw = 8'h96 ^ 8'(m);
            push_word(txw);
            sb.push_back(8'h3C);
            wait_idle();
            chk("mode_sclk_end", sclk, t_cpol);
            drain();
            chk("mode_slave_rx", s_rx, txw);
        end

        // LSB first
        t_cpol = 1'b0;
        t_cpha = 1'b0;
        cfg_cpol = 1'b0;
        cfg_cpha = 1'b0;
        cfg_div = 4'd0;
        cfg_lsb_first = 1'b1;
        loop = 1'b1;
        cycles(2);
        push_word(8'h01);
        sb.push_back(8'h01);
        @(posedge clk);
        #1;
        chk("lsb_first_mosi", mosi, 1'b1);
        wait_idle();
        drain();
        chk("lsb_bit_order", s_rx, 8'h80);
        cfg_lsb_first = 1'b0;

        // cs hold across queued words, TX full, RX overflow
        cfg_cs_sel = 2'd2;
        cfg_cs_hold = 1'b1;
        base = n_rise;
        push_word(8'h11);
        push_word(8'h22);
        mon_en = 1'b1;
        push_word(8'h33);
        push_word(8'h44);
        push_word(8'h55);
        chk("tx_full_set", tx_full, 1'b1);
        push_word(8'h66);
        chk("tx_full_still", tx_full, 1'b1);
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        sb.push_back(8'h33);
        sb.push_back(8'h44);
        wait_idle();
        cycles(2);
        mon_en = 1'b0;
        chk("hold_cs_glitches", cs_bad, 0);
        chk("hold_words_sent", n_rise - base, 40);
        chk("ovf_set", rx_ovf, 1'b1);
        drain();
        chk("rx_empty_after", rx_empty, 1'b1);
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", rx_ovf, 1'b0);
        cfg_cs_hold = 1'b0;
        cycles(2);
        chk("hold_release", cs_n, 4'b1111);

        // Async reset mid-word
        cfg_cpol = 1'b1;
        cfg_div = 4'd2;
        cfg_cs_sel = 2'd1;
        cycles(2);
        push_word(8'h55);
        push_word(8'hAA);
        cycles(2);
        chk("pre_rst_sclk", sclk, 1'b1);
        chk("pre_rst_cs", cs_n, 4'b1101);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sclk", sclk, 1'b0);
        chk("mid_rst_cs", cs_n, 4'b1111);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rx_empty", rx_empty, 1'b1);
        chk("mid_rst_tx_full", tx_full, 1'b0);
        chk("mid_rst_mosi", mosi, 1'b0);
        cycles(2);
        rst_n = 1'b1;
        cycles(60);
        chk("post_rst_no_rx", rx_empty, 1'b1);
        chk("post_rst_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
